// File: rtl/obstacle_gen_if.sv
// ============================================================================
// obstacle_gen_if : control inputs and slot outputs of the obstacle generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface obstacle_gen_if;
    logic        tick;
    logic        start;
    logic        crash;
    logic [3:0]  speed;
    logic [14:0] obstacle0;
    logic [14:0] obstacle1;
    logic        passed;
    logic        running;

    modport master (
        output tick, start, crash, speed,
        input  obstacle0, obstacle1, passed, running
    );

    modport slave (
        input  tick, start, crash, speed,
        output obstacle0, obstacle1, passed, running
    );
endinterface

`default_nettype wire

// File: rtl/obstacle_gen.sv
// ============================================================================
// obstacle_gen : two-slot scrolling obstacle spawner with LFSR-picked types.
// Macro OBSTACLE_BIRD_EN enables bird types (9..11) in the type table.
// Rev 1.0
// ============================================================================
`default_nettype none

module obstacle_gen #(
    parameter int          SPAWN_COL = 720,
    parameter int          MIN_GAP   = 180,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    obstacle_gen_if.slave  bus
);

    localparam logic [9:0] C_SPAWN_COL = 10'(SPAWN_COL);
    localparam logic [9:0] C_MIN_GAP   = 10'(MIN_GAP);
    localparam logic [9:0] C_DIST_MAX  = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [14:0] r_slot [2];
    logic [9:0]  r_dist;
    logic [9:0]  r_gap;
    logic        r_passed;
    logic        r_running;

    function automatic logic [3:0] type_lut(input logic [3:0] idx);
        logic [3:0] t;
        t = 4'd1;
        case (idx)
            4'd0:  t = 4'd1;
            4'd1:  t = 4'd2;
            4'd2:  t = 4'd3;
            4'd3:  t = 4'd5;
            4'd4:  t = 4'd6;
            4'd5:  t = 4'd7;
`ifdef OBSTACLE_BIRD_EN
            4'd6:  t = 4'd9;
            4'd7:  t = 4'd10;
            4'd8:  t = 4'd11;
`else
            4'd6:  t = 4'd1;
            4'd7:  t = 4'd5;
            4'd8:  t = 4'd2;
`endif
            4'd9:  t = 4'd1;
            4'd10: t = 4'd2;
            4'd11: t = 4'd3;
            4'd12: t = 4'd5;
            4'd13: t = 4'd6;
            4'd14: t = 4'd7;
            default: t = 4'd1;
        endcase
        return t;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    logic        w_lfsr_fb;
    logic [15:0] w_lfsr_next;
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = {w_lfsr_fb, r_lfsr[15:1]};

    logic [10:0] w_dist_sum;
    logic [9:0]  w_dist_next;
    logic [9:0]  w_gap_spawn;
    logic [3:0]  w_type;
    logic        w_move;
    logic        w_spawn;
    logic        w_spawn_idx;
    logic [1:0]  w_en;
    logic [1:0]  w_retire;
    logic [14:0] w_moved     [2];
    logic [14:0] w_next_slot [2];

    assign w_dist_sum  = {1'b0, r_dist} + {7'd0, bus.speed};
    assign w_dist_next = w_dist_sum[10] ? C_DIST_MAX : w_dist_sum[9:0];
    assign w_gap_spawn = C_MIN_GAP + {4'd0, r_lfsr[13:8]};
    assign w_type      = type_lut(r_lfsr[3:0]);

    // A zero speed step is a no-op, so it is not treated as a move at all
    assign w_move      = (r_state == ST_RUN) && !bus.crash && bus.tick && (bus.speed != 4'd0);
    assign w_spawn     = w_move && (w_dist_next >= r_gap) && !(w_en[0] && w_en[1]);
    assign w_spawn_idx = w_en[0];

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_slot
            assign w_en[i]     = r_slot[i][14];
            assign w_retire[i] = w_en[i] && (r_slot[i][9:0] <= {6'd0, bus.speed});
            assign w_moved[i]  = w_retire[i] ? 15'd0 :
                                 w_en[i]     ? {r_slot[i][14:10], r_slot[i][9:0] - {6'd0, bus.speed}} :
                                               r_slot[i];
            // Only a slot free before this tick may take the spawn
            assign w_next_slot[i] = (w_spawn && (w_spawn_idx == 1'(i))) ?
                                    {1'b1, w_type, C_SPAWN_COL} : w_moved[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_slot[0] <= 15'd0;
            r_slot[1] <= 15'd0;
            r_dist    <= 10'd0;
            r_gap     <= C_MIN_GAP;
            r_passed  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_passed <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (r_state == ST_IDLE) begin
                        r_slot[0] <= 15'd0;
                        r_slot[1] <= 15'd0;
                    end
                    if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_slot[0] <= 15'd0;
                        r_slot[1] <= 15'd0;
                        r_dist    <= 10'd0;
                        r_gap     <= C_MIN_GAP;
                    end
                end
                ST_RUN: begin
                    if (bus.crash) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                    end else if (w_move) begin
                        r_slot[0] <= w_next_slot[0];
                        r_slot[1] <= w_next_slot[1];
                        r_passed  <= |w_retire;
                        r_dist    <= w_spawn ? 10'd0 : w_dist_next;
                        r_gap     <= w_spawn ? w_gap_spawn : r_gap;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obstacle0 = r_slot[0];
    assign bus.obstacle1 = r_slot[1];
    assign bus.passed    = r_passed;
    assign bus.running   = r_running;

endmodule

`default_nettype wire
